// File: rtl/psum_adder_sched_pkg.sv
// psum_sched_pkg: shared definitions for the partial-sum adder sequencer.
//   state_t      - sequencer states
//   NUM_LANES    - number of PE psum lanes feeding the adder
//   DEST_MSB, SRC_MSB, PIX_MSB, DATA_LSB
//                - packet field positions for the default geometry
//                  (PWIDTH=47, ADDR_W=4, DWIDTH=8)
//   pkt_fields_t - packet layout for the default geometry
//   pad_width()  - zero-pad width between the pixel index and the sum
package psum_sched_pkg;

   typedef enum logic [1:0] {
      GATHER,
      ISSUE,
      WAIT_RES,
      SEND
   } state_t;

   localparam int unsigned NUM_LANES = 3;
   localparam int unsigned PIX_W     = 8;

   localparam int unsigned DEF_PWIDTH = 47;
   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned DEF_DWIDTH = 8;

   localparam int unsigned DEST_MSB = DEF_PWIDTH - 1;
   localparam int unsigned SRC_MSB  = DEST_MSB - DEF_ADDR_W;
   localparam int unsigned PIX_MSB  = SRC_MSB - DEF_ADDR_W;
   localparam int unsigned DATA_LSB = 0;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]                               dest;
      logic [DEF_ADDR_W-1:0]                               src;
      logic [PIX_W-1:0]                                    pix;
      logic [DEF_PWIDTH-2*DEF_ADDR_W-PIX_W-DEF_DWIDTH-1:0] pad;
      logic [DEF_DWIDTH-1:0]                               sum;
   } pkt_fields_t;

   function automatic int unsigned pad_width(input int unsigned pwidth,
                                             input int unsigned addr_w,
                                             input int unsigned dwidth);
      return pwidth - 2 * addr_w - PIX_W - dwidth;
   endfunction

endpackage

// File: rtl/psum_adder_sched_lane_reg.sv
// psum_lane_reg: one-entry valid/ready holding register for a single PE lane.
//   clk, reset  - clock, asynchronous active-high reset
//   in_valid    - operand offered by the lane
//   in_data     - operand value
//   clr         - drop the held operand (frees the entry)
//   in_ready    - entry is empty and can capture
//   full        - entry holds an operand
//   data        - held operand
module psum_lane_reg #(
   parameter int unsigned DWIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              clr,
   output logic              in_ready,
   output logic              full,
   output logic [DWIDTH-1:0] data
);

   logic              full_q, full_d;
   logic [DWIDTH-1:0] data_q, data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clr) begin
         full_d = 1'b0;
      end else if (in_valid && !full_q) begin
         full_d = 1'b1;
         data_d = in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign in_ready = ~full_q;
   assign full     = full_q;
   assign data     = data_q;

endmodule

// File: rtl/psum_adder_sched.sv
// psum_adder_sched: sequencer for the shared three-input partial-sum adder.
// Gathers one operand per PE lane, issues one add, captures the result and
// sends it as a destination-addressed packet tagged with a wrapping pixel
// index.
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_ready     - per-lane operand handshake (3 lanes)
//   in_data               - lane i at [i*DWIDTH +: DWIDTH]
//   add_valid/add_ready   - operand handshake to the adder
//   add_op0..add_op2      - held lane operands
//   add_res_valid/add_res - one-cycle result strobe and value
//   pkt_valid/pkt_ready   - packet handshake to the NoC port
//   pkt_data              - {DEST_ADDR, SRC_ADDR, pix_idx, zero pad, sum}
//   pix_idx               - index of the next pixel to be sent
//   done                  - one-cycle pulse when pixel NUM_PIX-1 is sent
//   res_err               - sticky: result strobe outside WAIT_RES
//   timeout_err           - sticky gather watchdog flag
// Build option: PSUM_GATHER_TIMEOUT_EN enables the gather watchdog;
// without it timeout_err is tied to 0.
module psum_adder_sched
   import psum_sched_pkg::*;
#(
   parameter int unsigned       DWIDTH      = 8,
   parameter int unsigned       PWIDTH      = 47,
   parameter int unsigned       ADDR_W      = 4,
   parameter logic [ADDR_W-1:0] SRC_ADDR    = 4'd0,
   parameter logic [ADDR_W-1:0] DEST_ADDR   = 4'd1,
   parameter int unsigned       NUM_PIX     = 25,
   parameter int unsigned       TIMEOUT_CYC = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_LANES-1:0]          in_valid,
   output logic [NUM_LANES-1:0]          in_ready,
   input  logic [NUM_LANES*DWIDTH-1:0]   in_data,
   output logic                          add_valid,
   input  logic                          add_ready,
   output logic [DWIDTH-1:0]             add_op0,
   output logic [DWIDTH-1:0]             add_op1,
   output logic [DWIDTH-1:0]             add_op2,
   input  logic                          add_res_valid,
   input  logic [DWIDTH-1:0]             add_res,
   output logic                          pkt_valid,
   input  logic                          pkt_ready,
   output logic [PWIDTH-1:0]             pkt_data,
   output logic [PIX_W-1:0]              pix_idx,
   output logic                          done,
   output logic                          res_err,
   output logic                          timeout_err
);

   localparam int unsigned      PAD_W    = pad_width(PWIDTH, ADDR_W, DWIDTH);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);

   logic [NUM_LANES-1:0] lane_full;
   logic [NUM_LANES-1:0] capture;
   logic [DWIDTH-1:0]    lane_data [NUM_LANES];
   logic                 lane_clr;
   logic                 all_full_nxt;

   state_t            state_q, state_d;
   logic              add_valid_q, add_valid_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic [DWIDTH-1:0] sum_q, sum_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              done_q, done_d;
   logic              res_err_q, res_err_d;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      psum_lane_reg #(.DWIDTH(DWIDTH)) u_lane (
         .clk      (clk),
         .reset    (reset),
         .in_valid (in_valid[i]),
         .in_data  (in_data[i*DWIDTH +: DWIDTH]),
         .clr      (lane_clr),
         .in_ready (in_ready[i]),
         .full     (lane_full[i]),
         .data     (lane_data[i])
      );
   end

   // Look at lane occupancy after this cycle's captures so the last operand
   // captured at cycle t reaches the adder at t+1.
   assign capture      = in_valid & in_ready;
   assign all_full_nxt = &(lane_full | capture);

   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      pix_d     = pix_q;
      done_d    = 1'b0;
      res_err_d = res_err_q;
      lane_clr  = 1'b0;

      unique case (state_q)
         GATHER: begin
            if (all_full_nxt) state_d = ISSUE;
         end
         ISSUE: begin
            if (add_ready) state_d = WAIT_RES;
         end
         WAIT_RES: begin
            if (add_res_valid) begin
               sum_d    = add_res;
               lane_clr = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (pkt_ready) begin
               if (pix_q == PIX_LAST) begin
                  pix_d  = '0;
                  done_d = 1'b1;
               end else begin
                  pix_d = pix_q + 1'b1;
               end
               state_d = all_full_nxt ? ISSUE : GATHER;
            end
         end
         default: state_d = GATHER;
      endcase

      if (add_res_valid && (state_q != WAIT_RES)) res_err_d = 1'b1;

      add_valid_d = (state_d == ISSUE);
      pkt_valid_d = (state_d == SEND);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= GATHER;
         add_valid_q <= 1'b0;
         pkt_valid_q <= 1'b0;
         sum_q       <= '0;
         pix_q       <= '0;
         done_q      <= 1'b0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         add_valid_q <= add_valid_d;
         pkt_valid_q <= pkt_valid_d;
         sum_q       <= sum_d;
         pix_q       <= pix_d;
         done_q      <= done_d;
         res_err_q   <= res_err_d;
      end
   end

`ifdef PSUM_GATHER_TIMEOUT_EN
   localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                                  $clog2(TIMEOUT_CYC + 1) : 8;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_err_q, timeout_err_d;

   // Counts only while a partial gather is stalled; any capture or leaving
   // GATHER restarts it. Saturates at the limit.
   always_comb begin
      to_cnt_d      = '0;
      timeout_err_d = timeout_err_q;
      if ((state_q == GATHER) && (|lane_full) && !(&lane_full) && !(|capture)) begin
         to_cnt_d = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;
         if (to_cnt_d == TO_LIMIT) timeout_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   // No watchdog in this build; TIMEOUT_CYC is kept for port/parameter
   // compatibility only.
   assign timeout_err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

   assign add_valid = add_valid_q;
   assign add_op0   = lane_data[0];
   assign add_op1   = lane_data[1];
   assign add_op2   = lane_data[2];
   assign pkt_valid = pkt_valid_q;
   assign pkt_data  = pkt_valid_q ? {DEST_ADDR, SRC_ADDR, pix_q, {PAD_W{1'b0}}, sum_q} : '0;
   assign pix_idx   = pix_q;
   assign done      = done_q;
   assign res_err   = res_err_q;

endmodule

// File: tb/tb_psum_adder_sched.sv
module tb_psum_adder_sched;

   localparam int DW      = 8;
   localparam int PW      = 47;
   localparam int AW      = 4;
   localparam int NPIX    = 25;
   localparam int TO_CYC  = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    in_valid;
   logic [2:0]    in_ready;
   logic [3*DW-1:0] in_data;
   logic          add_valid, add_ready;
   logic [DW-1:0] add_op0, add_op1, add_op2;
   logic          add_res_valid;
   logic [DW-1:0] add_res;
   logic          pkt_valid, pkt_ready;
   logic [PW-1:0] pkt_data;
   logic [7:0]    pix_idx;
   logic          done, res_err, timeout_err;

   int errors = 0;
   int checks = 0;
   int pix_model = 0;

   psum_adder_sched #(
      .DWIDTH(DW), .PWIDTH(PW), .ADDR_W(AW), .SRC_ADDR(4'd0), .DEST_ADDR(4'd1),
      .NUM_PIX(NPIX), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .add_valid(add_valid), .add_ready(add_ready),
      .add_op0(add_op0), .add_op1(add_op1), .add_op2(add_op2),
      .add_res_valid(add_res_valid), .add_res(add_res),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
      .pix_idx(pix_idx), .done(done), .res_err(res_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Packet as the NoC expects it: dest, src, pixel, zero pad, sum.
   function automatic logic [PW-1:0] exp_pkt(input int pix, input logic [DW-1:0] sum);
      logic [7:0] p;
      p = pix[7:0];
      return {4'd1, 4'd0, p, 23'd0, sum};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      pix_model = 0;
   endtask

   // Drive remaining handshakes of a transaction already in ISSUE; the adder
   // answers with sum one idle cycle after acceptance. No checking here.
   task automatic finish_txn(input logic [DW-1:0] sum, output logic [PW-1:0] pkt_seen,
                             output logic done_seen);
      add_ready = 1'b1; tick(); add_ready = 1'b0;
      tick();
      add_res_valid = 1'b1; add_res = sum; tick(); add_res_valid = 1'b0;
      pkt_seen = pkt_data;
      pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
      done_seen = done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      if (add_valid !== 1'b0) begin errors++; $display("FAIL rst_add_valid: got %b want 0", add_valid); end checks++;
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_pkt_valid: got %b want 0", pkt_valid); end checks++;
      if (in_ready !== 3'b111) begin errors++; $display("FAIL rst_in_ready: got %b want 111", in_ready); end checks++;
      if (pix_idx !== 8'd0) begin errors++; $display("FAIL rst_pix_idx: got %0d want 0", pix_idx); end checks++;
      if ({done, res_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {done, res_err, timeout_err}); end checks++;
      reset = 1'b0;
      tick();
      pix_model = 0;
   endtask

   task automatic test_basic();
      logic [PW-1:0] want;
      in_valid = 3'b111; in_data = {8'h07, 8'h05, 8'h03};
      tick();
      in_valid = 3'b000;
      if (add_valid !== 1'b1) begin errors++; $display("FAIL basic_add_valid: got %b want 1", add_valid); end checks++;
      if ({add_op2, add_op1, add_op0} !== 24'h070503) begin errors++; $display("FAIL basic_ops: got %h want 070503", {add_op2, add_op1, add_op0}); end checks++;
      if (in_ready !== 3'b000) begin errors++; $display("FAIL basic_in_ready: got %b want 000", in_ready); end checks++;
      add_ready = 1'b1; tick(); add_ready = 1'b0;
      if (add_valid !== 1'b0) begin errors++; $display("FAIL basic_add_drop: got %b want 0", add_valid); end checks++;
      tick();
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL basic_early_pkt: got %b want 0", pkt_valid); end checks++;
      add_res_valid = 1'b1; add_res = 8'h0F; tick(); add_res_valid = 1'b0;
      want = exp_pkt(pix_model, 8'h0F);
      if (pkt_valid !== 1'b1) begin errors++; $display("FAIL basic_pkt_valid: got %b want 1", pkt_valid); end checks++;
      if (pkt_data !== want) begin errors++; $display("FAIL basic_pkt_data: got %h want %h", pkt_data, want); end checks++;
      if (in_ready !== 3'b111) begin errors++; $display("FAIL basic_lanes_freed: got %b want 111", in_ready); end checks++;
      pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
      pix_model = (pix_model + 1) % NPIX;
      if (pix_idx !== 8'(pix_model)) begin errors++; $display("FAIL basic_pix_idx: got %0d want %0d", pix_idx, pix_model); end checks++;
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL basic_pkt_drop: got %b want 0", pkt_valid); end checks++;
   endtask

   task automatic test_staggered();
      logic [2:0] captured;
      logic [7:0] v [3];
      logic [PW-1:0] seen;
      logic dn;
      captured = 3'b000;
      for (int c = 0; c <= 9; c++) begin
         for (int l = 0; l < 3; l++) v[l] = 8'($urandom);
         in_valid = (c == 0) ? 3'b001 : (c == 4) ? 3'b010 : (c == 9) ? 3'b100 : 3'b000;
         in_data  = {v[2], v[1], v[0]};
         captured = captured | in_valid;
         tick();
         in_valid = 3'b000;
         if (in_ready !== ~captured) begin errors++; $display("FAIL stag_in_ready c=%0d: got %b want %b", c, in_ready, ~captured); end checks++;
         if (add_valid !== (c == 9)) begin errors++; $display("FAIL stag_add_valid c=%0d: got %b want %b", c, add_valid, (c == 9)); end checks++;
      end
      finish_txn(8'h5A, seen, dn);
      if (seen !== exp_pkt(pix_model, 8'h5A)) begin errors++; $display("FAIL stag_pkt: got %h want %h", seen, exp_pkt(pix_model, 8'h5A)); end checks++;
      pix_model = (pix_model + 1) % NPIX;
   endtask

   task automatic test_back_to_back();
      logic [7:0] a [3];
      logic [7:0] b [3];
      logic [PW-1:0] want, seen;
      logic dn;
      for (int l = 0; l < 3; l++) begin a[l] = 8'($urandom); b[l] = 8'($urandom); end
      in_valid = 3'b111; in_data = {a[2], a[1], a[0]}; tick(); in_valid = 3'b000;
      add_ready = 1'b1; tick(); add_ready = 1'b0;
      add_res_valid = 1'b1; add_res = a[0] + a[1] + a[2]; tick(); add_res_valid = 1'b0;
      want = exp_pkt(pix_model, a[0] + a[1] + a[2]);
      if (pkt_data !== want) begin errors++; $display("FAIL b2b_pkt_first: got %h want %h", pkt_data, want); end checks++;
      for (int s = 0; s < 5; s++) begin
         in_valid = (s == 0) ? 3'b111 : 3'b000;
         in_data  = {b[2], b[1], b[0]};
         tick();
         in_valid = 3'b000;
         if (pkt_valid !== 1'b1 || pkt_data !== want) begin errors++; $display("FAIL b2b_pkt_hold s=%0d: got %b/%h want 1/%h", s, pkt_valid, pkt_data, want); end checks++;
      end
      if (in_ready !== 3'b000) begin errors++; $display("FAIL b2b_refill: got %b want 000", in_ready); end checks++;
      pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
      pix_model = (pix_model + 1) % NPIX;
      if (add_valid !== 1'b1) begin errors++; $display("FAIL b2b_direct_issue: got %b want 1", add_valid); end checks++;
      if ({add_op2, add_op1, add_op0} !== {b[2], b[1], b[0]}) begin errors++; $display("FAIL b2b_ops: got %h want %h", {add_op2, add_op1, add_op0}, {b[2], b[1], b[0]}); end checks++;
      if (pix_idx !== 8'(pix_model)) begin errors++; $display("FAIL b2b_pix: got %0d want %0d", pix_idx, pix_model); end checks++;
      finish_txn(b[0] + b[1] + b[2], seen, dn);
      want = exp_pkt(pix_model, b[0] + b[1] + b[2]);
      if (seen !== want) begin errors++; $display("FAIL b2b_pkt_second: got %h want %h", seen, want); end checks++;
      pix_model = (pix_model + 1) % NPIX;
   endtask

   task automatic test_res_err_and_reset();
      in_valid = 3'b111; in_data = 24'($urandom); tick(); in_valid = 3'b000;
      add_res_valid = 1'b1; add_res = 8'($urandom); tick(); add_res_valid = 1'b0;
      if (res_err !== 1'b1) begin errors++; $display("FAIL reserr_set: got %b want 1", res_err); end checks++;
      if (add_valid !== 1'b1 || pkt_valid !== 1'b0) begin errors++; $display("FAIL reserr_state: got av=%b pv=%b want av=1 pv=0", add_valid, pkt_valid); end checks++;
      tick();
      if (res_err !== 1'b1 || add_valid !== 1'b1) begin errors++; $display("FAIL reserr_sticky: got err=%b av=%b want 1/1", res_err, add_valid); end checks++;
      add_ready = 1'b1; tick(); add_ready = 1'b0;
      #3 reset = 1'b1;
      #1;
      if ({add_valid, pkt_valid, done, res_err} !== 4'b0000) begin errors++; $display("FAIL async_rst_flags: got %b want 0000", {add_valid, pkt_valid, done, res_err}); end checks++;
      if (pkt_data !== '0 || pix_idx !== 8'd0) begin errors++; $display("FAIL async_rst_pkt: got %h/%0d want 0/0", pkt_data, pix_idx); end checks++;
      if (in_ready !== 3'b111) begin errors++; $display("FAIL async_rst_lanes: got %b want 111", in_ready); end checks++;
      tick();
      reset = 1'b0;
      tick();
      pix_model = 0;
   endtask

   task automatic test_pixel_wrap();
      int done_cnt;
      int done_at;
      logic [7:0] a [3];
      int d [3];
      int maxd;
      logic [7:0] sum;
      logic exp_done;
      logic [PW-1:0] want;
      do_reset();
      done_cnt = 0; done_at = -1;
      for (int t = 0; t < NPIX; t++) begin
         maxd = 0;
         for (int l = 0; l < 3; l++) begin
            a[l] = 8'($urandom); d[l] = $urandom_range(0, 3);
            if (d[l] > maxd) maxd = d[l];
         end
         sum = a[0] + a[1] + a[2];
         in_data = {a[2], a[1], a[0]};
         for (int c = 0; c <= maxd; c++) begin
            in_valid = {d[2] == c, d[1] == c, d[0] == c};
            tick();
            in_valid = 3'b000;
            if (add_valid !== (c == maxd)) begin errors++; $display("FAIL wrap_issue t=%0d c=%0d: got %b want %b", t, c, add_valid, (c == maxd)); end checks++;
         end
         if ({add_op2, add_op1, add_op0} !== {a[2], a[1], a[0]}) begin errors++; $display("FAIL wrap_ops t=%0d: got %h want %h", t, {add_op2, add_op1, add_op0}, {a[2], a[1], a[0]}); end checks++;
         repeat ($urandom_range(0, 2)) tick();
         add_ready = 1'b1; tick(); add_ready = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         add_res_valid = 1'b1; add_res = sum; tick(); add_res_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         want = exp_pkt(pix_model, sum);
         if (pkt_valid !== 1'b1 || pkt_data !== want) begin errors++; $display("FAIL wrap_pkt t=%0d: got %b/%h want 1/%h", t, pkt_valid, pkt_data, want); end checks++;
         pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
         exp_done = (pix_model == NPIX - 1);
         pix_model = (pix_model + 1) % NPIX;
         if (done !== exp_done) begin errors++; $display("FAIL wrap_done t=%0d: got %b want %b", t, done, exp_done); end checks++;
         if (pix_idx !== 8'(pix_model)) begin errors++; $display("FAIL wrap_pix t=%0d: got %0d want %0d", t, pix_idx, pix_model); end checks++;
         if (done === 1'b1) begin done_cnt++; done_at = t; end
         tick();
         if (done !== 1'b0) begin errors++; $display("FAIL wrap_done_width t=%0d: got %b want 0", t, done); end checks++;
      end
      if (done_cnt != 1 || done_at != NPIX - 1) begin errors++; $display("FAIL wrap_done_once: got count=%0d at=%0d want 1 at %0d", done_cnt, done_at, NPIX - 1); end checks++;
      if (pix_idx !== 8'd0 || res_err !== 1'b0) begin errors++; $display("FAIL wrap_final: got pix=%0d err=%b want 0/0", pix_idx, res_err); end checks++;
   endtask

   task automatic test_timeout();
      do_reset();
      in_valid = 3'b001; in_data = 24'h0000A5; tick(); in_valid = 3'b000;
      if (in_ready !== 3'b110) begin errors++; $display("FAIL to_lane0: got %b want 110", in_ready); end checks++;
      repeat (4) tick();
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", timeout_err); end checks++;
      repeat (10) tick();
`ifdef PSUM_GATHER_TIMEOUT_EN
      if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_fire: got %b want 1", timeout_err); end checks++;
`else
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_disabled: got %b want 0", timeout_err); end checks++;
`endif
      if (in_ready !== 3'b110 || add_valid !== 1'b0) begin errors++; $display("FAIL to_lanes_kept: got rdy=%b av=%b want 110/0", in_ready, add_valid); end checks++;
   endtask

   initial begin
      reset = 1'b1; in_valid = '0; in_data = '0; add_ready = 1'b0;
      add_res_valid = 1'b0; add_res = '0; pkt_ready = 1'b0;
      test_reset();
      test_basic();
      test_staggered();
      test_back_to_back();
      test_res_err_and_reset();
      test_pixel_wrap();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want completion before 200000");
      $fatal(1, "bench time limit reached");
   end

endmodule
